// File: rtl/reg_writeback_queue_if.sv
// Result handshake between execute/memory producers and the writeback queue.
// The producer drives valid/dest/data; the queue answers with ready.
interface reg_writeback_queue_if;
    logic       res_valid;
    logic       res_ready;
    logic [1:0] res_dest;
    logic [7:0] res_data;

    modport master (output res_valid, output res_dest, output res_data, input res_ready);
    modport slave  (input res_valid, input res_dest, input res_data, output res_ready);
endinterface

// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue: buffers completed results and drains one per cycle onto
// the 4x8 register file write port, with a per-register pending scoreboard.
// Optional macro WB_FORWARD_EN adds a combinational forwarding lookup
// (i_query_reg -> o_fwd_hit / o_fwd_data) over the output register and FIFO.
module reg_writeback_queue #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    reg_writeback_queue_if.slave res,
    input  logic                 i_wb_stall,
    input  logic                 i_flush,
`ifdef WB_FORWARD_EN
    input  logic [1:0]           i_query_reg,
    output logic                 o_fwd_hit,
    output logic [7:0]           o_fwd_data,
`endif
    output logic                 o_regwrite,
    output logic                 o_regdst,
    output logic [1:0]           o_reg_dest,
    output logic [7:0]           o_reg_write_data,
    output logic [3:0]           o_pending,
    output logic [AW:0]          o_count
);
    typedef enum logic [1:0] {IDLE, DRAIN, HOLD} state_t;

    logic [1:0]    r_mem_dest [DEPTH];
    logic [7:0]    r_mem_data [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_count;
    logic          r_regwrite;
    logic [1:0]    r_reg_dest;
    logic [7:0]    r_reg_data;
    logic [3:0]    r_pending;
    state_t        r_state, w_state_nxt;

    logic          w_full, w_enq, w_deq;
    logic [AW:0]   w_count_nxt;
    logic [AW-1:0] w_rptr_nxt, w_wptr_nxt;
    logic [3:0]    w_pend_nxt;

    // Ready depends on occupancy only, so a dequeue never opens a full queue early.
    assign w_full        = (r_count == (AW+1)'(DEPTH));
    assign res.res_ready = !w_full;
    assign w_enq         = res.res_valid && !w_full && !i_flush;
    assign w_deq         = (r_count != '0) && !i_wb_stall && !i_flush;
    assign w_rptr_nxt    = i_flush ? '0 : r_rptr + AW'(w_deq);
    assign w_wptr_nxt    = i_flush ? '0 : r_wptr + AW'(w_enq);
    assign w_count_nxt   = i_flush ? '0 : r_count + (AW+1)'(w_enq) - (AW+1)'(w_deq);

    assign o_regwrite       = r_regwrite;
    assign o_regdst         = 1'b1;
    assign o_reg_dest       = r_reg_dest;
    assign o_reg_write_data = r_reg_data;
    assign o_pending        = r_pending;
    assign o_count          = r_count;

    // Pending mask of the state after this edge, so it is visible from the accept cycle on.
    always_comb begin
        logic [AW-1:0] idx;
        w_pend_nxt = '0;
        idx        = '0;
        if (!i_flush) begin
            if (w_deq) w_pend_nxt[r_mem_dest[r_rptr]] = 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                idx = w_rptr_nxt + AW'(i);
                if ((AW+1)'(i) < w_count_nxt) begin
                    if (w_enq && idx == r_wptr) w_pend_nxt[res.res_dest]   = 1'b1;
                    else                        w_pend_nxt[r_mem_dest[idx]] = 1'b1;
                end
            end
        end
    end

    // Next-state logic; the datapath does not depend on the state, it tracks drain activity.
    always_comb begin
        w_state_nxt = r_state;
        if (i_flush) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_count_nxt != '0) w_state_nxt = DRAIN;
                DRAIN:   if (w_count_nxt == '0) w_state_nxt = IDLE;
                         else if (i_wb_stall)   w_state_nxt = HOLD;
                HOLD:    if (w_count_nxt == '0) w_state_nxt = IDLE;
                         else if (!i_wb_stall)  w_state_nxt = DRAIN;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Pointers, occupancy, output strobe register, pending mask and state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_regwrite <= 1'b0;
            r_reg_dest <= '0;
            r_reg_data <= '0;
            r_pending  <= '0;
            r_state    <= IDLE;
        end else begin
            r_wptr     <= w_wptr_nxt;
            r_rptr     <= w_rptr_nxt;
            r_count    <= w_count_nxt;
            r_regwrite <= w_deq;
            if (w_deq) begin
                r_reg_dest <= r_mem_dest[r_rptr];
                r_reg_data <= r_mem_data[r_rptr];
            end
            r_pending  <= w_pend_nxt;
            r_state    <= w_state_nxt;
        end
    end

    // FIFO storage; contents outside the valid window are don't-care, so no reset.
    always_ff @(posedge i_clk) begin
        if (w_enq) begin
            r_mem_dest[r_wptr] <= res.res_dest;
            r_mem_data[r_wptr] <= res.res_data;
        end
    end

`ifdef WB_FORWARD_EN
    // Scan oldest to youngest (output register first) so the last match wins.
    always_comb begin
        logic [AW-1:0] idx;
        o_fwd_hit  = 1'b0;
        o_fwd_data = '0;
        idx        = '0;
        if (r_regwrite && r_reg_dest == i_query_reg) begin
            o_fwd_hit  = 1'b1;
            o_fwd_data = r_reg_data;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = r_rptr + AW'(i);
            if ((AW+1)'(i) < r_count && r_mem_dest[idx] == i_query_reg) begin
                o_fwd_hit  = 1'b1;
                o_fwd_data = r_mem_data[idx];
            end
        end
    end
`endif
endmodule

// File: tb/tb_reg_writeback_queue.sv
// Bench for reg_writeback_queue: directed scenario tasks plus a scoreboard that
// records accepted results and compares them against every write strobe.
module tb_reg_writeback_queue;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stall = 1'b0;
    logic       flush = 1'b0;
    logic       regwrite, regdst;
    logic [1:0] reg_dest;
    logic [7:0] reg_data;
    logic [3:0] pending;
    logic [2:0] count;
`ifdef WB_FORWARD_EN
    logic [1:0] query = 2'd0;
    logic       fwd_hit;
    logic [7:0] fwd_data;
`endif

    int checks   = 0;
    int failures = 0;
    int strobes  = 0;
    logic [9:0] sb[$];

    reg_writeback_queue_if rif();

    reg_writeback_queue #(.DEPTH(4)) dut (
        .i_clk(clk), .i_rst(rst), .res(rif), .i_wb_stall(stall), .i_flush(flush),
`ifdef WB_FORWARD_EN
        .i_query_reg(query), .o_fwd_hit(fwd_hit), .o_fwd_data(fwd_data),
`endif
        .o_regwrite(regwrite), .o_regdst(regdst), .o_reg_dest(reg_dest),
        .o_reg_write_data(reg_data), .o_pending(pending), .o_count(count)
    );

    always #5 clk = ~clk;

    // Scoreboard: compare each strobe with the oldest accepted entry, then log new acceptances.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (regwrite) begin
                strobes++;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_strobe unexpected got=%h/%h required=none", reg_dest, reg_data);
                end else if ({reg_dest, reg_data} !== sb[0]) begin
                    failures++;
                    $display("FAIL sb_strobe got=%h required=%h", {reg_dest, reg_data}, sb[0]);
                    void'(sb.pop_front());
                end else begin
                    void'(sb.pop_front());
                end
            end
            if (flush) sb.delete();
            else if (rif.res_valid && rif.res_ready) sb.push_back({rif.res_dest, rif.res_data});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        checks++;
        if ({regwrite, regdst, reg_dest, reg_data, pending, count, rif.res_ready} !== {1'b0, 1'b1, 2'd0, 8'd0, 4'd0, 3'd0, 1'b1}) begin
            failures++;
            $display("FAIL reset_vals got=%b %b %h %h %b %0d %b required=0 1 0 00 0000 0 1",
                     regwrite, regdst, reg_dest, reg_data, pending, count, rif.res_ready);
        end
        rst = 1'b0;
        cyc();
        checks++;
        if (count !== 3'd0 || regwrite !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got=count %0d regwrite %b required=0 0", count, regwrite);
        end
    endtask

    task automatic test_single();
        rif.res_valid = 1'b1; rif.res_dest = 2'd2; rif.res_data = 8'h5A;
        cyc();
        rif.res_valid = 1'b0;
        checks++;
        if (regwrite !== 1'b0 || pending !== 4'b0100 || count !== 3'd1) begin
            failures++;
            $display("FAIL single_accept got=%b %b %0d required=0 0100 1", regwrite, pending, count);
        end
        cyc();
        checks++;
        if (regwrite !== 1'b1 || reg_dest !== 2'd2 || reg_data !== 8'h5A || pending !== 4'b0100) begin
            failures++;
            $display("FAIL single_strobe got=%b %0d %h %b required=1 2 5a 0100", regwrite, reg_dest, reg_data, pending);
        end
        cyc();
        checks++;
        if (regwrite !== 1'b0 || pending !== 4'b0000) begin
            failures++;
            $display("FAIL single_done got=%b %b required=0 0000", regwrite, pending);
        end
    endtask

    task automatic test_stall_full();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rif.res_valid = 1'b1; rif.res_dest = 2'(i); rif.res_data = 8'(8'h30 + i);
            cyc();
        end
        checks++;
        if (count !== 3'd4 || rif.res_ready !== 1'b0 || regwrite !== 1'b0 || pending !== 4'b1111) begin
            failures++;
            $display("FAIL full got=%0d %b %b %b required=4 0 0 1111", count, rif.res_ready, regwrite, pending);
        end
        rif.res_dest = 2'd3; rif.res_data = 8'hFF;
        cyc();
        cyc();
        checks++;
        if (count !== 3'd4 || rif.res_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_refuse got=%0d %b required=4 0", count, rif.res_ready);
        end
        rif.res_valid = 1'b0;
        stall = 1'b0;
        cyc();
        checks++;
        if (rif.res_ready !== 1'b1 || count !== 3'd3 || regwrite !== 1'b1 || reg_data !== 8'h30) begin
            failures++;
            $display("FAIL release got=%b %0d %b %h required=1 3 1 30", rif.res_ready, count, regwrite, reg_data);
        end
        for (int k = 1; k < 4; k++) begin
            cyc();
            checks++;
            if (regwrite !== 1'b1 || reg_data !== 8'(8'h30 + k) || reg_dest !== 2'(k)) begin
                failures++;
                $display("FAIL drain_%0d got=%b %0d %h required=1 %0d %h", k, regwrite, reg_dest, reg_data, k, 8'(8'h30 + k));
            end
        end
        cyc();
        checks++;
        if (regwrite !== 1'b0 || count !== 3'd0) begin
            failures++;
            $display("FAIL drain_end got=%b %0d required=0 0", regwrite, count);
        end
    endtask

    task automatic test_same_reg();
        rif.res_valid = 1'b1; rif.res_dest = 2'd1; rif.res_data = 8'h11;
        cyc();
        rif.res_data = 8'h22;
        cyc();
        rif.res_valid = 1'b0;
        checks++;
        if (regwrite !== 1'b1 || reg_data !== 8'h11 || pending !== 4'b0010) begin
            failures++;
            $display("FAIL same_first got=%b %h %b required=1 11 0010", regwrite, reg_data, pending);
        end
        cyc();
        checks++;
        if (regwrite !== 1'b1 || reg_data !== 8'h22 || pending !== 4'b0010) begin
            failures++;
            $display("FAIL same_second got=%b %h %b required=1 22 0010", regwrite, reg_data, pending);
        end
        cyc();
        checks++;
        if (regwrite !== 1'b0 || pending !== 4'b0000) begin
            failures++;
            $display("FAIL same_done got=%b %b required=0 0000", regwrite, pending);
        end
    endtask

    task automatic test_flush();
        int n;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rif.res_valid = 1'b1; rif.res_dest = 2'(i); rif.res_data = 8'(8'h40 + i);
            cyc();
        end
        rif.res_valid = 1'b0;
        stall = 1'b0;
        cyc();
        checks++;
        if (regwrite !== 1'b1 || reg_data !== 8'h40 || count !== 3'd2) begin
            failures++;
            $display("FAIL flush_pre got=%b %h %0d required=1 40 2", regwrite, reg_data, count);
        end
        n = strobes;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        checks++;
        if (count !== 3'd0 || pending !== 4'b0000 || regwrite !== 1'b0 || rif.res_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_clear got=%0d %b %b %b required=0 0000 0 1", count, pending, regwrite, rif.res_ready);
        end
        repeat (3) cyc();
        checks++;
        if (strobes !== n + 1) begin
            failures++;
            $display("FAIL flush_strobes got=%0d required=%0d", strobes - n, 1);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rif.res_valid = 1'b1; rif.res_dest = 2'(i); rif.res_data = 8'(8'h50 + i);
            cyc();
        end
        rif.res_valid = 1'b0;
        stall = 1'b0;
        cyc();
        checks++;
        if (regwrite !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre got=%b required=1", regwrite);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({regwrite, regdst, reg_dest, reg_data, pending, count, rif.res_ready} !== {1'b0, 1'b1, 2'd0, 8'd0, 4'd0, 3'd0, 1'b1}) begin
            failures++;
            $display("FAIL rstmid_async got=%b %b %h %h %b %0d %b required=0 1 0 00 0000 0 1",
                     regwrite, regdst, reg_dest, reg_data, pending, count, rif.res_ready);
        end
        n = strobes;
        cyc();
        checks++;
        if (regwrite !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_edge got=%b required=0", regwrite);
        end
        rst = 1'b0;
        cyc();
        cyc();
        checks++;
        if (strobes !== n || count !== 3'd0) begin
            failures++;
            $display("FAIL rstmid_after got=strobes %0d count %0d required=0 0", strobes - n, count);
        end
    endtask

`ifdef WB_FORWARD_EN
    task automatic test_forward();
        stall = 1'b1;
        rif.res_valid = 1'b1; rif.res_dest = 2'd3; rif.res_data = 8'hA0;
        cyc();
        rif.res_data = 8'hB0;
        cyc();
        rif.res_valid = 1'b0;
        query = 2'd3;
        #1;
        checks++;
        if (fwd_hit !== 1'b1 || fwd_data !== 8'hB0) begin
            failures++;
            $display("FAIL fwd_hit got=%b %h required=1 b0", fwd_hit, fwd_data);
        end
        query = 2'd0;
        #1;
        checks++;
        if (fwd_hit !== 1'b0 || fwd_data !== 8'h00) begin
            failures++;
            $display("FAIL fwd_miss got=%b %h required=0 00", fwd_hit, fwd_data);
        end
        stall = 1'b0;
        repeat (4) cyc();
    endtask
`endif

    task automatic test_back_to_back();
        logic acc;
        int   sent = 0;
        int   budget;
        rif.res_valid = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (!rif.res_valid && sent < 24) begin
                rif.res_valid = ($urandom_range(0, 3) != 0);
                rif.res_dest  = 2'($urandom_range(0, 3));
                rif.res_data  = 8'($urandom_range(0, 255));
            end
            stall = ($urandom_range(0, 4) == 0);
            #2 acc = rif.res_valid && rif.res_ready;
            cyc();
            if (acc) begin
                sent++;
                rif.res_valid = 1'b0;
            end
        end
        rif.res_valid = 1'b0;
        stall = 1'b0;
        budget = 20;
        while ((count != 3'd0 || regwrite) && budget > 0) begin
            cyc();
            budget--;
        end
        cyc();
        checks++;
        if (budget == 0 || sb.size() != 0 || count !== 3'd0) begin
            failures++;
            $display("FAIL b2b_drain got=left %0d count %0d budget %0d required=0 0 >0", sb.size(), count, budget);
        end
    endtask

    initial begin
        rif.res_valid = 1'b0;
        rif.res_dest  = 2'd0;
        rif.res_data  = 8'd0;
        test_reset();
        test_single();
        test_stall_full();
        test_same_reg();
        test_flush();
        test_reset_mid();
`ifdef WB_FORWARD_EN
        test_forward();
`endif
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
